// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel gradient stage: two row line buffers, zero-padded borders,
// saturated |Gx|+|Gy| magnitude and 4-bin direction. Optional macro SOBEL_THRESH_EN adds a thresh port.
module sobel_stream_filter #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int MAG_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pixel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MAG_W-1:0]  grad_mag,
  output logic [1:0]        grad_dir,
  output logic              out_last
`ifdef SOBEL_THRESH_EN
  ,
  input  logic [MAG_W-1:0]  thresh
`endif
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = $clog2(IMG_H + 1);
  localparam int GW = DATA_W + 3;
  localparam int SW = GW + 1;
  localparam int DW = GW + 3;
  localparam logic [SW-1:0] MAG_MAX = SW'((1 << MAG_W) - 1);

  typedef enum logic [0:0] {S_RUN = 1'b0, S_FLUSH = 1'b1} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [DATA_W-1:0] r_lb0 [IMG_W];
  logic [DATA_W-1:0] r_lb1 [IMG_W];
  logic [2:0][DATA_W-1:0] r_col1;
  logic [2:0][DATA_W-1:0] r_col2;
  logic r_tail;
  logic r_tail_last;
  logic r_s1_v;
  logic r_s1_last;
  logic signed [GW-1:0] r_gx;
  logic signed [GW-1:0] r_gy;
  logic r_out_valid;
  logic [MAG_W-1:0] r_mag;
  logic [1:0] r_dir;
  logic r_last;

  logic w_en;
  logic w_step;
  logic w_last_col;
  logic w_res_v;
  logic [2:0][DATA_W-1:0] w_col;
  logic [2:0][DATA_W-1:0] w_win_l;
  logic [2:0][DATA_W-1:0] w_win_c;
  logic [2:0][DATA_W-1:0] w_win_r;
  logic signed [GW-1:0] w_gx;
  logic signed [GW-1:0] w_gy;
  logic [GW-1:0] w_ax;
  logic [GW-1:0] w_ay;
  logic [SW-1:0] w_sum;
  logic [MAG_W-1:0] w_sat;
  logic [MAG_W-1:0] w_mag;
  logic [DW-1:0] w_ax2;
  logic [DW-1:0] w_ay2;
  logic [DW-1:0] w_ax5;
  logic [DW-1:0] w_ay5;
  logic [1:0] w_dir;

  function automatic logic signed [GW-1:0] col_sum(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b,
                                                   input logic [DATA_W-1:0] c);
    col_sum = $signed({3'b000, a}) + $signed({2'b00, b, 1'b0}) + $signed({3'b000, c});
  endfunction

  assign w_en       = !r_out_valid || out_ready;
  assign in_ready   = !rst && (r_state == S_RUN) && w_en;
  // Flush cycles behave like accepted zero pixels of the virtual row below the frame.
  assign w_step     = w_en && (((r_state == S_RUN) && in_valid) || (r_state == S_FLUSH));
  assign w_last_col = (r_x == XW'(IMG_W - 1));

  assign out_valid = r_out_valid;
  assign grad_mag  = r_mag;
  assign grad_dir  = r_dir;
  assign out_last  = r_last;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: leave RUN after the frame's final pixel, return after one flushed row.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN: begin
        if (w_step && w_last_col && (r_y == YW'(IMG_H - 1))) begin
          w_state_nxt = S_FLUSH;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_FLUSH: begin
        if (w_step && w_last_col) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_FLUSH;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Raster position of the next accepted (or injected) pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_step) begin
      if (w_last_col) begin
        r_x <= '0;
        r_y <= (r_state == S_FLUSH) ? YW'(0) : (r_y + YW'(1));
      end else begin
        r_x <= r_x + XW'(1);
      end
    end
  end

  // Incoming column; rows above the frame are forced to zero from the row counter.
  always_comb begin
    w_col[0] = (r_y >= YW'(2)) ? r_lb1[r_x] : '0;
    w_col[1] = (r_y >= YW'(1)) ? r_lb0[r_x] : '0;
    w_col[2] = (r_state == S_RUN) ? in_pixel : '0;
  end

  // Line buffers: lb0 holds the previous row, lb1 the row before it.
  always_ff @(posedge clk) begin
    if (w_step) begin
      r_lb1[r_x] <= r_lb0[r_x];
      r_lb0[r_x] <= w_col[2];
    end
  end

  // Two most recent columns of the sliding window.
  always_ff @(posedge clk) begin
    if (w_step) begin
      r_col2 <= r_col1;
      r_col1 <= w_col;
    end
  end

  // The last column of a row completes together with its left neighbour, so it is
  // emitted one enabled cycle later with a zero right column.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tail      <= 1'b0;
      r_tail_last <= 1'b0;
    end else if (w_en) begin
      r_tail      <= w_step && w_last_col && (r_y != YW'(0));
      r_tail_last <= (r_state == S_FLUSH);
    end
  end

  // Window selection for the result finishing this cycle.
  always_comb begin
    w_win_c = r_col1;
    if (r_tail) begin
      w_win_l = r_col2;
      w_win_r = '0;
    end else begin
      w_win_l = (r_x >= XW'(2)) ? r_col2 : '0;
      w_win_r = w_col;
    end
  end

  assign w_res_v = r_tail || (w_step && (r_x != XW'(0)) && (r_y != YW'(0)));
  assign w_gx = col_sum(w_win_r[0], w_win_r[1], w_win_r[2]) - col_sum(w_win_l[0], w_win_l[1], w_win_l[2]);
  assign w_gy = col_sum(w_win_l[2], w_win_c[2], w_win_r[2]) - col_sum(w_win_l[0], w_win_c[0], w_win_r[0]);

  // Gradient stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v    <= 1'b0;
      r_s1_last <= 1'b0;
      r_gx      <= '0;
      r_gy      <= '0;
    end else if (w_en) begin
      r_s1_v    <= w_res_v;
      r_s1_last <= r_tail && r_tail_last;
      r_gx      <= w_gx;
      r_gy      <= w_gy;
    end
  end

  assign w_ax  = r_gx[GW-1] ? GW'(-r_gx) : GW'(r_gx);
  assign w_ay  = r_gy[GW-1] ? GW'(-r_gy) : GW'(r_gy);
  assign w_sum = {1'b0, w_ax} + {1'b0, w_ay};
  assign w_sat = (w_sum > MAG_MAX) ? MAG_MAX[MAG_W-1:0] : w_sum[MAG_W-1:0];
  assign w_ax2 = {2'b00, w_ax, 1'b0};
  assign w_ay2 = {2'b00, w_ay, 1'b0};
  assign w_ax5 = {1'b0, w_ax, 2'b00} + {3'b000, w_ax};
  assign w_ay5 = {1'b0, w_ay, 2'b00} + {3'b000, w_ay};

`ifdef SOBEL_THRESH_EN
  assign w_mag = (w_sat < thresh) ? '0 : w_sat;
`else
  assign w_mag = w_sat;
`endif

  // Direction binning; a zero gradient component counts as positive.
  always_comb begin
    w_dir = 2'd0;
    if (w_ay5 <= w_ax2) begin
      w_dir = 2'd0;
    end else if (w_ax5 <= w_ay2) begin
      w_dir = 2'd2;
    end else if (r_gx[GW-1] == r_gy[GW-1]) begin
      w_dir = 2'd1;
    end else begin
      w_dir = 2'd3;
    end
  end

  // Output register, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_mag       <= '0;
      r_dir       <= 2'd0;
      r_last      <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= r_s1_v;
      r_mag       <= w_mag;
      r_dir       <= w_dir;
      r_last      <= r_s1_v && r_s1_last;
    end
  end

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Randomised self-checking bench for sobel_stream_filter on an 8x8 frame, compared
// against a padded-frame arithmetic model.
module tb_sobel_stream_filter;

  localparam int W = 8;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_pixel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] grad_mag;
  logic [1:0] grad_dir;
  logic       out_last;
  logic [7:0] thr;

  sobel_stream_filter #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .MAG_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .grad_mag(grad_mag), .grad_dir(grad_dir),
    .out_last(out_last)
`ifdef SOBEL_THRESH_EN
    , .thresh(thr)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int img [H][W];
  logic [7:0] pq[$];
  int eq_mag[$];
  int eq_dir[$];
  int eq_last[$];
  int got_mag [256];
  int got_dir [256];
  int got_last [256];
  int out_cnt, acc_cnt, acc_cyc, first_cyc, cyc;
  int last_count, last_pos1, last_pos2;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int px(input int x, input int y);
    if (x < 0 || x >= W || y < 0 || y >= H) return 0;
    return img[y][x];
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Padded-frame reference: magnitude and direction of one output pixel.
  task automatic model_pixel(input int x, input int y, output int mag, output int dir);
    int gx, gy, ax, ay;
    gx = (px(x+1,y-1) + 2*px(x+1,y) + px(x+1,y+1)) - (px(x-1,y-1) + 2*px(x-1,y) + px(x-1,y+1));
    gy = (px(x-1,y+1) + 2*px(x,y+1) + px(x+1,y+1)) - (px(x-1,y-1) + 2*px(x,y-1) + px(x+1,y-1));
    ax = iabs(gx);
    ay = iabs(gy);
    mag = (ax + ay > 255) ? 255 : ax + ay;
`ifdef SOBEL_THRESH_EN
    if (mag < int'(thr)) mag = 0;
`endif
    if (5*ay <= 2*ax) dir = 0;
    else if (5*ax <= 2*ay) dir = 2;
    else if ((gx >= 0) == (gy >= 0)) dir = 1;
    else dir = 3;
  endtask

  // kind: 0 flat 0x80, 1 vertical step, 2 random, 3 zeros, 4 random 0/255.
  task automatic load_frame(input int kind);
    int m, d;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        case (kind)
          0: img[y][x] = 128;
          1: img[y][x] = (x >= 4) ? 16 : 0;
          2: img[y][x] = int'($urandom_range(0, 255));
          3: img[y][x] = 0;
          default: img[y][x] = ($urandom_range(0, 1) == 1) ? 255 : 0;
        endcase
        pq.push_back(8'(img[y][x]));
      end
    end
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        model_pixel(x, y, m, d);
        eq_mag.push_back(m);
        eq_dir.push_back(d);
        eq_last.push_back((x == W-1 && y == H-1) ? 1 : 0);
      end
    end
  endtask

  // rmode: 0 always ready, 1 ready one cycle in three, 2 random.
  task automatic drive(input int vpct, input int rmode, input int stop_acc);
    bit prev_stall;
    int pmag, pdir, plast, budget;
    prev_stall = 0; pmag = 0; pdir = 0; plast = 0;
    out_cnt = 0; acc_cnt = 0; acc_cyc = -1; first_cyc = -1; cyc = 0;
    last_count = 0; last_pos1 = -1; last_pos2 = -1;
    budget = 4000;
    while (pq.size() > 0 || eq_mag.size() > 0) begin
      if (stop_acc > 0 && acc_cnt == stop_acc) break;
      if (cyc >= budget) begin
        check("timeout_pending", pq.size() + eq_mag.size(), 0);
        break;
      end
      @(negedge clk);
      in_valid  = (pq.size() > 0) && ($urandom_range(0, 99) < vpct);
      in_pixel  = (pq.size() > 0) ? pq[0] : 8'h00;
      out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) begin
        check("hold_mag", int'(grad_mag), pmag);
        check("hold_dir", int'(grad_dir), pdir);
        check("hold_last", int'(out_last), plast);
      end
      if (out_valid && !out_ready) check("stall_in_ready", int'(in_ready), 0);
      prev_stall = out_valid && !out_ready;
      pmag = int'(grad_mag); pdir = int'(grad_dir); plast = int'(out_last);
      if (in_valid && in_ready) begin
        void'(pq.pop_front());
        acc_cnt++;
        if (acc_cnt == W + 2) acc_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        if (eq_mag.size() == 0) begin
          check("extra_result", out_cnt, -1);
        end else begin
          check("mag", int'(grad_mag), eq_mag.pop_front());
          check("dir", int'(grad_dir), eq_dir.pop_front());
          check("last", int'(out_last), eq_last.pop_front());
        end
        if (out_cnt == 0) first_cyc = cyc;
        if (out_last) begin
          last_count++;
          if (last_count == 1) last_pos1 = out_cnt;
          else last_pos2 = out_cnt;
        end
        got_mag[out_cnt % 256] = int'(grad_mag);
        got_dir[out_cnt % 256] = int'(grad_dir);
        got_last[out_cnt % 256] = int'(out_last);
        out_cnt++;
      end
      cyc++;
    end
    if (stop_acc == 0) begin
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (4) begin
        @(negedge clk);
        #1 check("idle_no_valid", int'(out_valid), 0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pixel = 8'h00; out_ready = 1'b1; thr = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_mag", int'(grad_mag), 0);
    check("rst_last", int'(out_last), 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("in_ready_after_rst", int'(in_ready), 1);

    // Flat frame, full rate.
    load_frame(0);
    drive(100, 0, 0);
    check("latency", first_cyc - acc_cyc, 2);
    check("count_t1", out_cnt, 64);
    check("t1_c00_mag", got_mag[0], 255);
    check("t1_c00_dir", got_dir[0], 1);
    check("t1_c70_mag", got_mag[7], 255);
    check("t1_c70_dir", got_dir[7], 3);
    check("t1_int_mag", got_mag[27], 0);
    check("t1_int_dir", got_dir[27], 0);

    // Vertical step, then the same image under back-pressure.
    load_frame(1);
    drive(100, 0, 0);
    check("t2_x3_mag", got_mag[3*W+3], 64);
    check("t2_x4_mag", got_mag[3*W+4], 64);
    check("t2_x4_dir", got_dir[3*W+4], 0);
    check("t2_x2_mag", got_mag[3*W+2], 0);
    check("t2_x5_mag", got_mag[3*W+5], 0);
    load_frame(1);
    drive(80, 1, 0);
    check("count_t3", out_cnt, 64);
    check("t3_x3_mag", got_mag[5*W+3], 64);

    // Back-to-back frames.
    load_frame(2);
    load_frame(3);
    drive(100, 0, 0);
    check("t4_last_count", last_count, 2);
    check("t4_last_pos1", last_pos1, 63);
    check("t4_last_pos2", last_pos2, 127);
    check("t4_f2_first", got_mag[64], 0);

    // Reset in mid-frame.
    load_frame(0);
    drive(100, 0, 20);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("t5_out_valid", int'(out_valid), 0);
    check("t5_mag", int'(grad_mag), 0);
    check("t5_dir", int'(grad_dir), 0);
    check("t5_in_ready", int'(in_ready), 0);
    rst = 1'b0;
    pq.delete(); eq_mag.delete(); eq_dir.delete(); eq_last.delete();
    load_frame(0);
    drive(100, 0, 0);
    check("t5_c00_mag", got_mag[0], 255);
    check("t5_c70_dir", got_dir[7], 3);

    // Randomised frames and handshakes.
    for (int i = 0; i < 4; i++) begin
      load_frame(2 + 2 * (i % 2));
      load_frame(4);
      drive(60, 2, 0);
      check("rand_count", out_cnt, 128);
    end

`ifdef SOBEL_THRESH_EN
    thr = 8'h41;
    load_frame(1);
    drive(100, 0, 0);
    check("t6_thr41", got_mag[3*W+3], 0);
    thr = 8'h40;
    load_frame(1);
    drive(100, 0, 0);
    check("t6_thr40", got_mag[3*W+3], 64);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
